// File: rtl/ode_mem_pkg.sv
// rtl/ode_mem_pkg.sv - shared constants and state encodings for the ODE working-RAM arbiter
package ode_mem_pkg;

  localparam int DEFAULT_WORD_SIZE    = 16;
  localparam int DEFAULT_ADDRESS_SIZE = 16;

  localparam int REQ_STEP   = 0;
  localparam int REQ_SOLVER = 1;
  localparam int REQ_HOST   = 2;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first set request at or after ptr, with wrap
module rr_picker #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin, lockable arbiter sharing the dual-read-port working RAM
module ram_port_arbiter
  import ode_mem_pkg::*;
#(
  parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
  parameter int NUM_REQ      = 3,
  parameter int LOCK_MAX     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              we,
  input  logic [NUM_REQ-1:0]              lock,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0] addr1_in,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0] addr2_in,
  input  logic [NUM_REQ*WORD_SIZE-1:0]    wdata_in,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [WORD_SIZE-1:0]            rdata1,
  output logic [WORD_SIZE-1:0]            rdata2,
  output logic                            lock_err,
  output logic                            ram_we,
  output logic [ADDRESS_SIZE-1:0]         ram_addr1,
  output logic [ADDRESS_SIZE-1:0]         ram_addr2,
  output logic [WORD_SIZE-1:0]            ram_wdata,
  input  logic [WORD_SIZE-1:0]            ram_rdata1,
  input  logic [WORD_SIZE-1:0]            ram_rdata2
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e              state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d, owner_q, owner_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    lock_err_q, lock_err_d;
  logic [NUM_REQ-1:0]      rvalid_q;
  logic [WORD_SIZE-1:0]    rdata1_q, rdata2_q, wdata_q;
  logic [ADDRESS_SIZE-1:0] addr1_q, addr2_q;

  logic [NUM_REQ-1:0]      pick_gnt, gnt_w;
  logic [PW-1:0]           gidx;
  logic                    any_gnt;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  rr_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt)
  );

  // While reset is held no requester may see a grant, even with req high.
  always_comb begin
    gnt_w = '0;
    if (rst) begin
      if (state_q == ST_LOCKED) gnt_w[owner_q] = req[owner_q];
      else                      gnt_w = pick_gnt;
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_w[i]) gidx = PW'(i);
  end

  assign any_gnt   = |gnt_w;
  assign gnt       = gnt_w;
  assign ram_we    = any_gnt & we[gidx];
  assign ram_addr1 = any_gnt ? addr1_in[int'(gidx)*ADDRESS_SIZE +: ADDRESS_SIZE] : addr1_q;
  assign ram_addr2 = any_gnt ? addr2_in[int'(gidx)*ADDRESS_SIZE +: ADDRESS_SIZE] : addr2_q;
  assign ram_wdata = any_gnt ? wdata_in[int'(gidx)*WORD_SIZE +: WORD_SIZE] : wdata_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    lock_err_d = lock_err_q;
    case (state_q)
      ST_ARB: begin
        if (any_gnt) begin
          ptr_d = wrap_inc(gidx);
          if (lock[gidx]) begin
            state_d = ST_LOCKED;
            owner_d = gidx;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (req[owner_q] && lock[owner_q]) begin
          // cnt counts grants already held; this cycle's grant is number cnt+1.
          if (cnt_q + 1'b1 == CW'(LOCK_MAX)) begin
            state_d    = ST_ARB;
            cnt_d      = '0;
            lock_err_d = 1'b1;
            ptr_d      = wrap_inc(owner_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_ARB;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_ARB;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      lock_err_q <= 1'b0;
      rvalid_q   <= '0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      lock_err_q <= lock_err_d;
      rvalid_q   <= gnt_w & ~we;
      if (any_gnt) begin
        addr1_q <= ram_addr1;
        addr2_q <= ram_addr2;
        wdata_q <= ram_wdata;
        if (!we[gidx]) begin
          rdata1_q <= ram_rdata1;
          rdata2_q <= ram_rdata2;
        end
      end
    end
  end

  assign rvalid   = rvalid_q;
  assign rdata1   = rdata1_q;
  assign rdata2   = rdata2_q;
  assign lock_err = lock_err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed and randomized checks of ram_port_arbiter against a reference model
module tb_ram_port_arbiter;

  localparam int N        = 3;
  localparam int WS       = 16;
  localparam int AS       = 16;
  localparam int LOCK_MAX = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req = '0, we = '0, lock = '0;
  logic [AS-1:0] a1 [N];
  logic [AS-1:0] a2 [N];
  logic [WS-1:0] wd [N];
  logic [AS-1:0] n_a1 [N];
  logic [AS-1:0] n_a2 [N];
  logic [WS-1:0] n_wd [N];
  logic [N-1:0]  n_req, n_we, n_lock;

  logic [N*AS-1:0] addr1_in, addr2_in;
  logic [N*WS-1:0] wdata_in;
  logic [N-1:0]    gnt, rvalid;
  logic [WS-1:0]   rdata1, rdata2, ram_wdata, ram_rdata1, ram_rdata2;
  logic [AS-1:0]   ram_addr1, ram_addr2;
  logic            lock_err, ram_we;

  always #5 clk = ~clk;

  always_comb begin
    addr1_in = '0;
    addr2_in = '0;
    wdata_in = '0;
    for (int i = 0; i < N; i++) begin
      addr1_in[i*AS +: AS] = a1[i];
      addr2_in[i*AS +: AS] = a2[i];
      wdata_in[i*WS +: WS] = wd[i];
    end
  end

  ram_port_arbiter #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS), .NUM_REQ(N), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
    .addr1_in(addr1_in), .addr2_in(addr2_in), .wdata_in(wdata_in),
    .gnt(gnt), .rvalid(rvalid), .rdata1(rdata1), .rdata2(rdata2), .lock_err(lock_err),
    .ram_we(ram_we), .ram_addr1(ram_addr1), .ram_addr2(ram_addr2), .ram_wdata(ram_wdata),
    .ram_rdata1(ram_rdata1), .ram_rdata2(ram_rdata2)
  );

  // Working RAM: array read, clocked write; low 8 address bits decode.
  logic [WS-1:0] ram_mem [256] = '{default: '0};
  logic          pl_en = 1'b0;
  logic [7:0]    pl_addr = '0;
  logic [WS-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr1[7:0]] <= ram_wdata;
    if (pl_en)  ram_mem[pl_addr] <= pl_data;
  end
  assign ram_rdata1 = ram_mem[ram_addr1[7:0]];
  assign ram_rdata2 = ram_mem[ram_addr2[7:0]];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: arbitration rules stated as "who owns the RAM this cycle".
  logic [WS-1:0] shadow [256] = '{default: '0};
  int            m_ptr, m_owner, m_held;
  bit            m_locked, m_lock_err;
  logic [N-1:0]  m_rvalid;
  logic [WS-1:0] m_rd1, m_rd2, m_wd;
  logic [AS-1:0] m_a1, m_a2;

  function automatic void model_reset();
    m_ptr = 0; m_owner = 0; m_held = 0; m_locked = 0; m_lock_err = 0;
    m_rvalid = '0; m_rd1 = '0; m_rd2 = '0; m_wd = '0; m_a1 = '0; m_a2 = '0;
  endfunction

  function automatic int model_grant();
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic void model_advance(input int g);
    if (g >= 0 && !we[g]) begin
      m_rvalid = N'(1 << g);
      m_rd1    = shadow[a1[g][7:0]];
      m_rd2    = shadow[a2[g][7:0]];
    end else begin
      m_rvalid = '0;
    end
    if (g >= 0) begin
      m_a1 = a1[g]; m_a2 = a2[g]; m_wd = wd[g];
      if (we[g]) shadow[a1[g][7:0]] = wd[g];
    end
    if (!m_locked) begin
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (lock[g]) begin m_locked = 1; m_owner = g; m_held = 1; end
      end
    end else if (g >= 0 && lock[m_owner]) begin
      m_held++;
      if (m_held == LOCK_MAX) begin
        m_locked = 0; m_lock_err = 1; m_ptr = (m_owner + 1) % N;
      end
    end else begin
      m_locked = 0;
    end
  endfunction

  int            last_g;
  logic [N-1:0]  o_gnt, o_rvalid;
  logic [WS-1:0] o_rd1, o_rd2;
  logic          o_we, o_lerr;

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0] l);
    int g;
    @(posedge clk);
    #1;
    req = r; we = w; lock = l;
    for (int i = 0; i < N; i++) begin a1[i] = n_a1[i]; a2[i] = n_a2[i]; wd[i] = n_wd[i]; end
    #3;
    g = model_grant();
    o_gnt = gnt; o_rvalid = rvalid; o_rd1 = rdata1; o_rd2 = rdata2; o_we = ram_we; o_lerr = lock_err;
    check("gnt",       32'(gnt),       32'((g >= 0) ? (1 << g) : 0));
    check("ram_we",    32'(ram_we),    32'((g >= 0) ? we[g] : 1'b0));
    check("ram_addr1", 32'(ram_addr1), 32'((g >= 0) ? a1[g] : m_a1));
    check("ram_addr2", 32'(ram_addr2), 32'((g >= 0) ? a2[g] : m_a2));
    check("ram_wdata", 32'(ram_wdata), 32'((g >= 0) ? wd[g] : m_wd));
    check("rvalid",    32'(rvalid),    32'(m_rvalid));
    check("rdata1",    32'(rdata1),    32'(m_rd1));
    check("rdata2",    32'(rdata2),    32'(m_rd2));
    check("lock_err",  32'(lock_err),  32'(m_lock_err));
    model_advance(g);
    last_g = g;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = '1;
    model_reset();
    #3;
    check("rst_gnt",      32'(gnt),       32'(0));
    check("rst_rvalid",   32'(rvalid),    32'(0));
    check("rst_rdata",    32'({rdata1, rdata2}), 32'(0));
    check("rst_lock_err", 32'(lock_err),  32'(0));
    check("rst_ram_we",   32'(ram_we),    32'(0));
    check("rst_ram_addr", 32'({ram_addr1, ram_addr2}), 32'(0));
    req = '0; we = '0; lock = '0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a1[i] = '0; a2[i] = '0; wd[i] = '0; n_a1[i] = '0; n_a2[i] = '0; n_wd[i] = '0;
    end
    model_reset();
    last_g = -1;
    // Preload while reset is held.
    @(negedge clk); pl_en = 1'b1; pl_addr = 8'h10; pl_data = 16'h1234;
    @(negedge clk); pl_addr = 8'h11; pl_data = 16'h5678;
    @(negedge clk); pl_en = 1'b0;
    shadow[8'h10] = 16'h1234;
    shadow[8'h11] = 16'h5678;
    do_reset(1);

    // Single read with one-cycle data return.
    n_a1[0] = 16'h0010; n_a2[0] = 16'h0011;
    step(3'b001, 3'b000, 3'b000);
    check("t1_gnt", 32'(o_gnt), 32'(3'b001));
    step(3'b000, 3'b000, 3'b000);
    check("t1_rvalid", 32'(o_rvalid), 32'(3'b001));
    check("t1_rdata1", 32'(o_rd1), 32'(16'h1234));
    check("t1_rdata2", 32'(o_rd2), 32'(16'h5678));

    // Round-robin rotation under full load.
    do_reset(1);
    for (int c = 0; c < 6; c++) begin
      step(3'b111, 3'b000, 3'b000);
      check("t2_rr", 32'(o_gnt), 32'(3'b001 << (c % 3)));
    end

    // Write then read of the same word.
    n_a1[1] = 16'h0020; n_wd[1] = 16'hBEEF; n_a1[0] = 16'h0020;
    step(3'b010, 3'b010, 3'b000);
    check("t3_wr_gnt", 32'(o_gnt), 32'(3'b010));
    check("t3_wr_we",  32'(o_we),  32'(1));
    step(3'b001, 3'b000, 3'b000);
    check("t3_rd_we",  32'(o_we),     32'(0));
    check("t3_no_rv",  32'(o_rvalid), 32'(0));
    step(3'b000, 3'b000, 3'b000);
    check("t3_rvalid", 32'(o_rvalid), 32'(3'b001));
    check("t3_rdata1", 32'(o_rd1),    32'(16'hBEEF));

    // Lock held past LOCK_MAX is force-released.
    step(3'b010, 3'b000, 3'b000);
    for (int c = 0; c < LOCK_MAX; c++) begin
      step(3'b111, 3'b000, 3'b100);
      check("t4_locked_gnt", 32'(o_gnt), 32'(3'b100));
    end
    step(3'b111, 3'b000, 3'b100);
    check("t4_after_gnt", 32'(o_gnt),  32'(3'b001));
    check("t4_lock_err",  32'(o_lerr), 32'(1));

    // Lock dropped early returns to normal arbitration.
    do_reset(1);
    step(3'b010, 3'b000, 3'b000);
    for (int c = 0; c < 3; c++) begin
      step(3'b111, 3'b000, 3'b100);
      check("t5_locked_gnt", 32'(o_gnt), 32'(3'b100));
    end
    step(3'b011, 3'b000, 3'b000);
    check("t5_release_gnt", 32'(o_gnt), 32'(3'b000));
    step(3'b011, 3'b000, 3'b000);
    check("t5_next_gnt",  32'(o_gnt),  32'(3'b001));
    check("t5_lock_err",  32'(o_lerr), 32'(0));

    // Reset right after a granted read drops the pending rvalid.
    step(3'b100, 3'b000, 3'b000);
    do_reset(2);
    step(3'b111, 3'b000, 3'b000);
    check("t6_first_gnt", 32'(o_gnt),    32'(3'b001));
    check("t6_no_rvalid", 32'(o_rvalid), 32'(0));

    // Randomized traffic; waiting requesters hold their request stable.
    n_req = '0; n_we = '0; n_lock = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || last_g == i) begin
          if (last_g == i && lock[i] && $urandom_range(0, 7) != 0) begin
            n_req[i]  = 1'b1;
            n_lock[i] = 1'b1;
          end else begin
            n_req[i]  = 1'($urandom_range(0, 1));
            n_lock[i] = ($urandom_range(0, 3) == 0);
          end
          n_we[i] = ($urandom_range(0, 2) == 0);
          n_a1[i] = 16'($urandom);
          n_a2[i] = 16'($urandom);
          n_wd[i] = 16'($urandom);
        end
      end
      if (c == 300) begin
        do_reset(1);
        n_req = '0;
      end
      step(n_req, n_we, n_lock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
